// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback versus a 2-deep buffered MDU result stream.
// Writes are combinational from state; an MDU result writes >=1 cycle after acceptance and wins after STARVE_LIMIT losses.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pipe_valid_i,
  input  logic        pipe_wen_i,
  input  logic [4:0]  pipe_dst_i,
  input  logic [63:0] pipe_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_dst_i,
  input  logic [63:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        pipe_stall_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [63:0] rf_wdata_o,
  output logic [1:0]  buf_count_o
);

  localparam int unsigned SW = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] data;
  } mdu_ent_t;

  mdu_ent_t      mem_q [2];
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] starve_q, starve_d;

  logic     preq;
  logic     mgnt;
  logic     mdu_ready;
  logic     push;
  mdu_ent_t head;

  always_comb begin
    preq      = pipe_valid_i & pipe_wen_i & (pipe_dst_i != 5'd0);
    head      = mem_q[rd_ptr_q];
    // A full buffer always drains, so a push at count 2 is always paired with a pop.
    mgnt      = ~reset_i & (count_q != 2'd0) &
                (~preq | (count_q == 2'd2) | (starve_q == LIMIT));
    mdu_ready = reset_i | (count_q != 2'd2) | mgnt;
    push      = ~reset_i & mdu_valid_i & mdu_ready & (mdu_dst_i != 5'd0);
  end

  always_comb begin
    rf_wen_o     = 1'b0;
    rf_waddr_o   = 5'd0;
    rf_wdata_o   = 64'd0;
    pipe_stall_o = 1'b0;
    if (mgnt) begin
      rf_wen_o     = 1'b1;
      rf_waddr_o   = head.dst;
      rf_wdata_o   = head.data;
      pipe_stall_o = preq;
    end else if (preq && !reset_i) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = pipe_dst_i;
      rf_wdata_o = pipe_data_i;
    end
  end

  assign mdu_ready_o = mdu_ready;
  assign buf_count_o = reset_i ? 2'd0 : count_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = mgnt ? ~rd_ptr_q : rd_ptr_q;
    starve_d = starve_q;
    case ({push, mgnt})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (mgnt || count_q == 2'd0) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      starve_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {mdu_dst_i, mdu_data_i};
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_wb_port_arbiter;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_wen;
  logic [4:0]  pipe_dst;
  logic [63:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_dst;
  logic [63:0] mdu_data;
  logic        mdu_ready, pipe_stall, rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [1:0]  buf_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pipe_valid_i (pipe_valid),
    .pipe_wen_i   (pipe_wen),
    .pipe_dst_i   (pipe_dst),
    .pipe_data_i  (pipe_data),
    .mdu_valid_i  (mdu_valid),
    .mdu_dst_i    (mdu_dst),
    .mdu_data_i   (mdu_data),
    .mdu_ready_o  (mdu_ready),
    .pipe_stall_o (pipe_stall),
    .rf_wen_o     (rf_wen),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .buf_count_o  (buf_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending MDU results in a queue, plus the count of cycles the head has waited.
  logic [68:0] mq[$];
  int          starve = 0;

  always @(negedge clk) begin : model_cmp
    bit          preq, m, e_wen, e_stall, e_rdy;
    int          n;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    preq    = pipe_valid && pipe_wen && (pipe_dst != 5'd0);
    n       = mq.size();
    m       = 1'b0;
    e_wen   = 1'b0;
    e_stall = 1'b0;
    e_addr  = 5'd0;
    e_data  = 64'd0;
    e_rdy   = 1'b1;
    if (!reset) begin
      m     = (n > 0) && (!preq || n == 2 || starve == LIM);
      e_rdy = (n < 2) || m;
      if (m) begin
        e_wen   = 1'b1;
        e_addr  = mq[0][68:64];
        e_data  = mq[0][63:0];
        e_stall = preq;
      end else if (preq) begin
        e_wen  = 1'b1;
        e_addr = pipe_dst;
        e_data = pipe_data;
      end
    end
    check("m_wen",   rf_wen,     e_wen);
    check("m_waddr", rf_waddr,   e_addr);
    check("m_wdata", rf_wdata,   e_data);
    check("m_stall", pipe_stall, e_stall);
    check("m_ready", mdu_ready,  e_rdy);
    check("m_count", buf_count,  reset ? 0 : n);
    if (reset) begin
      mq.delete();
      starve = 0;
    end else begin
      if (m) void'(mq.pop_front());
      if (mdu_valid && e_rdy && mdu_dst != 5'd0) mq.push_back({mdu_dst, mdu_data});
      if (m || n == 0) starve = 0;
      else if (starve < LIM) starve++;
    end
  end

  task automatic drive(input bit pv, input bit pw, input logic [4:0] pd, input logic [63:0] pdat,
                       input bit mv, input logic [4:0] md, input logic [63:0] mdat);
    pipe_valid = pv;
    pipe_wen   = pw;
    pipe_dst   = pd;
    pipe_data  = pdat;
    mdu_valid  = mv;
    mdu_dst    = md;
    mdu_data   = mdat;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // Reset with busy inputs: outputs must stay in the reset state.
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 64'hdead, 1'b1, 5'd7, 64'hbeef);
    mid();
    check("rst_wen",   rf_wen,     0);
    check("rst_stall", pipe_stall, 0);
    check("rst_ready", mdu_ready,  1);
    check("rst_count", buf_count,  0);
    check("rst_waddr", rf_waddr,   0);
    next();

    // Single MDU result with an idle pipe: written the following cycle.
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h11);
    mid();
    check("s1_c0_wen",   rf_wen,    0);
    check("s1_c0_count", buf_count, 0);
    next();
    idle();
    mid();
    check("s1_wen",   rf_wen,    1);
    check("s1_waddr", rf_waddr,  5);
    check("s1_wdata", rf_wdata,  64'h11);
    check("s1_count", buf_count, 1);
    next();
    mid();
    check("s1_after_count", buf_count, 0);
    check("s1_after_wen",   rf_wen,    0);
    next();

    // Continuous pipeline traffic: buffered MDU result waits LIM cycles then wins once.
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'hab);
    mid();
    check("s2_c0_waddr", rf_waddr,   3);
    check("s2_c0_stall", pipe_stall, 0);
    next();
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      mid();
      check("s2_pipe_waddr", rf_waddr,   3);
      check("s2_pipe_stall", pipe_stall, 0);
      next();
    end
    mid();
    check("s2_mdu_waddr", rf_waddr,   9);
    check("s2_mdu_wdata", rf_wdata,   64'hab);
    check("s2_mdu_stall", pipe_stall, 1);
    next();
    mid();
    check("s2_post_waddr", rf_waddr,   3);
    check("s2_post_stall", pipe_stall, 0);
    check("s2_post_count", buf_count,  0);
    next();

    // Fill to two, then full-buffer grant with a simultaneous push; order A1, A2, A4.
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd1, 64'ha1);
    next();
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd2, 64'ha2);
    mid();
    check("s3_c1_waddr", rf_waddr,  3);
    check("s3_c1_count", buf_count, 1);
    next();
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'ha4);
    mid();
    check("s3_full_count", buf_count,  2);
    check("s3_full_stall", pipe_stall, 1);
    check("s3_full_ready", mdu_ready,  1);
    check("s3_a1_waddr",   rf_waddr,   1);
    check("s3_a1_wdata",   rf_wdata,   64'ha1);
    next();
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
    mid();
    check("s3_keep_count", buf_count, 2);
    check("s3_a2_waddr",   rf_waddr,  2);
    check("s3_a2_wdata",   rf_wdata,  64'ha2);
    next();
    mid();
    check("s3_c4_waddr", rf_waddr,   3);
    check("s3_c4_stall", pipe_stall, 0);
    next();
    idle();
    mid();
    check("s3_a4_waddr", rf_waddr, 4);
    check("s3_a4_wdata", rf_wdata, 64'ha4);
    next();

    // Writes to register 0 from both sources are dropped.
    drive(1'b1, 1'b1, 5'd0, 64'h77, 1'b1, 5'd0, 64'h55);
    mid();
    check("s4_wen",   rf_wen,     0);
    check("s4_stall", pipe_stall, 0);
    check("s4_ready", mdu_ready,  1);
    next();
    idle();
    mid();
    check("s4_count", buf_count, 0);
    check("s4_wen2",  rf_wen,    0);
    next();

    // Reset pulse with a full buffer discards both entries.
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd6, 64'hb6);
    next();
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'hb7);
    next();
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 5'd8, 64'hb8);
    mid();
    check("s5_rst_wen",   rf_wen,     0);
    check("s5_rst_stall", pipe_stall, 0);
    check("s5_rst_ready", mdu_ready,  1);
    next();
    reset = 1'b0;
    idle();
    mid();
    check("s5_count", buf_count, 0);
    check("s5_wen",   rf_wen,    0);
    check("s5_ready", mdu_ready, 1);
    next();
    mid();
    check("s5_wen2", rf_wen, 0);
    next();

    // Mixed traffic pattern (including non-writing pipe ops and a mid-run reset), model-checked.
    for (int i = 0; i < 48; i++) begin
      reset = (i == 30);
      drive((i % 3) != 0, (i % 4) != 1, 5'((i * 7) % 32), 64'(i * 32'h101),
            ((i % 2) == 0) || ((i % 5) == 0), 5'((i * 3) % 32), 64'hf000 + 64'(i));
      next();
    end
    reset = 1'b0;
    idle();
    repeat (4) next();
    mid();
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
